// File: rtl/beat_tone_player.sv
// Beat-driven tone player: fetches a note word from a synchronous score ROM on
// every beat change and drives a square wave at that note's pitch.
module beat_tone_player #(
    parameter int CLK_HZ = 100000000,
    parameter int AW     = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic [AW-1:0] ibeat,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [4:0]    note_code,
    output logic          audio_out,
    output logic          beat_tick,
    output logic          busy,
    output logic          bad_note
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY} state_t;

    localparam int FREQ [12] = '{262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494};

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_last_ibeat;
    logic [AW-1:0] r_rom_addr;
    logic          r_beat_tick;
    logic [4:0]    r_note_p0;
    logic          r_vld_p0;
    logic [4:0]    r_note_code;
    logic          r_bad_note;
    logic [23:0]   r_cnt;
    logic          r_audio;

    logic          w_change;
    logic          w_fetch;
    logic          w_tick;
    logic          w_capture;
    logic          w_note_ok;
    logic [4:0]    w_note_nxt;
    logic [23:0]   w_half;
    logic [23:0]   w_half_tab [32];
    logic          w_unused_hi;

    // Codes 1..12 are octave 4, 13..24 octave 5; everything else is silent.
    for (genvar g = 0; g < 32; g++) begin : g_half
        if (g >= 1 && g <= 24) begin : g_note
            localparam int F = FREQ[(g - 1) % 12] * ((g - 1) / 12 + 1);
            assign w_half_tab[g] = 24'(CLK_HZ / (2 * F));
        end else begin : g_rest
            assign w_half_tab[g] = '0;
        end
    end

    assign w_change    = (ibeat != r_last_ibeat);
    assign w_half      = w_half_tab[r_note_code];
    assign w_note_ok   = (r_note_p0 <= 5'd24);
    assign w_unused_hi = ^rom_data[7:5];

    // Note taking effect on the next edge; enable loss wins over a pending load.
    always_comb begin
        w_note_nxt = r_note_code;
        if (!enable) begin
            w_note_nxt = 5'd0;
        end else if (r_vld_p0) begin
            w_note_nxt = w_note_ok ? r_note_p0 : 5'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fetch     = 1'b0;
        w_tick      = 1'b0;
        w_capture   = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FETCH;
                    w_fetch     = 1'b1;
                end
                S_FETCH: begin
                    if (w_change) begin
                        w_fetch = 1'b1;
                        w_tick  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_change) begin
                        w_state_nxt = S_FETCH;
                        w_fetch     = 1'b1;
                        w_tick      = 1'b1;
                    end else begin
                        w_state_nxt = S_PLAY;
                        w_capture   = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_change) begin
                        w_state_nxt = S_FETCH;
                        w_fetch     = 1'b1;
                        w_tick      = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Stage p0: ROM word captured in LOAD, applied to the tone one edge later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_ibeat <= '0;
            r_rom_addr   <= '0;
            r_beat_tick  <= 1'b0;
            r_note_p0    <= '0;
            r_vld_p0     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_ibeat <= ibeat;
            r_beat_tick  <= w_tick;
            r_vld_p0     <= w_capture;
            if (w_fetch) begin
                r_rom_addr <= ibeat;
            end
            if (w_capture) begin
                r_note_p0 <= rom_data[4:0];
            end
        end
    end

    // A pitch change restarts the phase; a repeated pitch keeps counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note_code <= '0;
            r_bad_note  <= 1'b0;
            r_cnt       <= '0;
            r_audio     <= 1'b0;
        end else begin
            r_note_code <= w_note_nxt;
            if (enable && r_vld_p0 && !w_note_ok) begin
                r_bad_note <= 1'b1;
            end
            if (w_note_nxt != r_note_code || w_note_nxt == 5'd0) begin
                r_cnt   <= '0;
                r_audio <= 1'b0;
            end else if (r_cnt == w_half - 24'd1) begin
                r_cnt   <= '0;
                r_audio <= ~r_audio;
            end else begin
                r_cnt <= r_cnt + 24'd1;
            end
        end
    end

    assign rom_addr  = r_rom_addr;
    assign note_code = r_note_code;
    assign audio_out = r_audio;
    assign beat_tick = r_beat_tick;
    assign busy      = (r_state == S_FETCH) || (r_state == S_LOAD);
    assign bad_note  = r_bad_note;

endmodule

// File: tb/tb_beat_tone_player.sv
// Directed bench for beat_tone_player at CLK_HZ=1 MHz with a one-cycle
// synchronous score ROM model; outputs are sampled on the falling edge.
module tb_beat_tone_player;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] ibeat;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic [4:0]    note_code;
    logic          audio_out;
    logic          beat_tick;
    logic          busy;
    logic          bad_note;

    logic [7:0]    rom [0:4095];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    beat_tone_player #(.CLK_HZ(1000000), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ibeat     (ibeat),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_code (note_code),
        .audio_out (audio_out),
        .beat_tick (beat_tick),
        .busy      (busy),
        .bad_note  (bad_note)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        rom[0]    = 8'd1;
        rom[4]    = 8'd10;
        rom[5]    = 8'd10;
        rom[6]    = 8'd13;
        rom[7]    = 8'd0;
        rom[8]    = 8'd27;
        rom[9]    = 8'hE3;
        rom[11]   = 8'd20;
        rom[4094] = 8'd12;

        reset = 1'b1; enable = 1'b0; ibeat = '0;
        step(2);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_note", 32'(note_code), 0);
        check("rst_audio", 32'(audio_out), 0);
        check("rst_tick", 32'(beat_tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_bad", 32'(bad_note), 0);

        // First fetch after release: A4, half-period 1136
        reset = 1'b0; enable = 1'b1; ibeat = 12'd5;
        step(1);
        check("first_rom_addr", 32'(rom_addr), 5);
        check("first_busy_fetch", 32'(busy), 1);
        check("first_no_tick", 32'(beat_tick), 0);
        step(1);
        check("first_busy_load", 32'(busy), 1);
        check("first_note_early", 32'(note_code), 0);
        step(1);
        check("first_busy_play", 32'(busy), 0);
        check("first_note_edge2", 32'(note_code), 0);
        step(1);
        check("first_note", 32'(note_code), 10);
        check("first_audio0", 32'(audio_out), 0);
        step(1135);
        check("a4_before_half", 32'(audio_out), 0);
        step(1);
        check("a4_at_half", 32'(audio_out), 1);

        // Beat 5->6 while audio high: C5 with phase restart
        ibeat = 12'd6;
        step(1);
        check("b6_tick", 32'(beat_tick), 1);
        check("b6_busy1", 32'(busy), 1);
        check("b6_rom_addr", 32'(rom_addr), 6);
        step(1);
        check("b6_tick_off", 32'(beat_tick), 0);
        check("b6_busy2", 32'(busy), 1);
        step(1);
        check("b6_busy_off", 32'(busy), 0);
        check("b6_note_old", 32'(note_code), 10);
        step(1);
        check("b6_note", 32'(note_code), 13);
        check("b6_restart", 32'(audio_out), 0);
        step(953);
        check("c5_before_half", 32'(audio_out), 0);
        step(1);
        check("c5_at_half", 32'(audio_out), 1);

        // Beat changes again during FETCH: stale word for beat 11 must not land
        ibeat = 12'd11;
        step(1);
        check("restart_tick1", 32'(beat_tick), 1);
        ibeat = 12'd7;
        step(1);
        check("restart_tick2", 32'(beat_tick), 1);
        check("restart_rom_addr", 32'(rom_addr), 7);
        step(1);
        check("restart_tick_off", 32'(beat_tick), 0);
        step(1);
        check("restart_note_old", 32'(note_code), 13);
        step(1);
        check("restart_rest_note", 32'(note_code), 0);
        check("restart_rest_audio", 32'(audio_out), 0);
        step(5);
        check("rest_hold", 32'(audio_out), 0);

        // Out-of-range word, then a valid word with junk in the upper bits
        ibeat = 12'd8;
        step(3);
        check("bad_before", 32'(bad_note), 0);
        step(1);
        check("bad_set", 32'(bad_note), 1);
        check("bad_note_rest", 32'(note_code), 0);
        ibeat = 12'd9;
        step(4);
        check("bad_sticky", 32'(bad_note), 1);
        check("upper_bits_ignored", 32'(note_code), 3);

        // Enable dropped in LOAD, beat moved while idle, then re-enable
        ibeat = 12'd5;
        step(2);
        check("drop_in_load", 32'(busy), 1);
        enable = 1'b0;
        step(1);
        check("drop_note", 32'(note_code), 0);
        check("drop_audio", 32'(audio_out), 0);
        check("drop_busy", 32'(busy), 0);
        ibeat = 12'd4;
        step(2);
        check("idle_no_tick", 32'(beat_tick), 0);
        check("idle_busy", 32'(busy), 0);
        enable = 1'b1;
        step(1);
        check("reen_rom_addr", 32'(rom_addr), 4);
        check("reen_busy", 32'(busy), 1);
        check("reen_no_tick", 32'(beat_tick), 0);
        step(3);
        check("reen_note", 32'(note_code), 10);
        check("reen_audio", 32'(audio_out), 0);

        // Same note on beats 4 and 5: phase carries across the boundary
        step(1000);
        ibeat = 12'd5;
        step(1);
        check("same_tick", 32'(beat_tick), 1);
        step(134);
        check("same_before_half", 32'(audio_out), 0);
        check("same_note", 32'(note_code), 10);
        step(1);
        check("same_at_half", 32'(audio_out), 1);

        // Beat index wrap
        ibeat = 12'd4094;
        step(4);
        check("wrap_note_4094", 32'(note_code), 12);
        ibeat = 12'd0;
        step(1);
        check("wrap_tick", 32'(beat_tick), 1);
        check("wrap_rom_addr", 32'(rom_addr), 0);
        step(3);
        check("wrap_note_0", 32'(note_code), 1);

        // Reset in the middle of a fetch
        ibeat = 12'd6;
        step(1);
        check("mid_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_note", 32'(note_code), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_rom_addr", 32'(rom_addr), 0);
        check("mid_rst_bad", 32'(bad_note), 0);
        check("mid_rst_audio", 32'(audio_out), 0);
        step(1);
        reset = 1'b0;
        step(1);
        check("post_rst_rom_addr", 32'(rom_addr), 6);
        check("post_rst_busy", 32'(busy), 1);
        check("post_rst_no_partial", 32'(note_code), 0);
        step(3);
        check("post_rst_note", 32'(note_code), 13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
